// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single RAM port between requester 0 (CPU MAR/MDR side) and
//   requester 1 (program loader / debug port). Round-robin grant; each
//   access runs IDLE -> ACCESS -> RESP and completes with a one-cycle ack.
//
//   state  | meaning
//   IDLE   | waiting for a request; grants on the edge a request is seen
//   ACCESS | RAM strobe and address driven for exactly one cycle
//   RESP   | strobes low, ack pulse to the granted requester
//
// Ports
//   Clock, clear_n          clock (rising edge), async active-low reset
//   rX_req/we/addr/wdata    requester X command, held until rX_ack
//   rX_ack, rX_rdata        completion pulse, read data (held between reads)
//   mem_read/mem_write      RAM strobes, never both high
//   mem_address/data_in     RAM address / write data
//   mem_data_out            RAM read data (combinational from the RAM)
//   busy                    high in ACCESS and RESP
//   rX_grant_cnt            saturating grant counters, present only when
//                           MEM_ARB_PERF_CNT_EN is defined
//
// Every output comes from a flop; there is no combinational req->mem path.

module mem_port_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 9
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  parameter int CNT_WIDTH     = 16
`endif
) (
  input  logic                     Clock,
  input  logic                     clear_n,
  input  logic                     r0_req,
  input  logic                     r0_we,
  input  logic [ADDRESS_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0]    r0_wdata,
  output logic                     r0_ack,
  output logic [DATA_WIDTH-1:0]    r0_rdata,
  input  logic                     r1_req,
  input  logic                     r1_we,
  input  logic [ADDRESS_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0]    r1_wdata,
  output logic                     r1_ack,
  output logic [DATA_WIDTH-1:0]    r1_rdata,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_data_in,
  input  logic [DATA_WIDTH-1:0]    mem_data_out,
  output logic                     busy
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]     r0_grant_cnt,
  output logic [CNT_WIDTH-1:0]     r1_grant_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_nx;

  logic                     take;        // grant happens on this edge
  logic                     gnt_sel;     // requester being granted
  logic                     last_grant;
  logic                     cur_id;      // requester owning the current access
  logic                     sel_we;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]    sel_wdata;

  always_ff @(posedge Clock or negedge clear_n) begin
    if (!clear_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    take     = 1'b0;
    gnt_sel  = 1'b0;
    case (state)
      IDLE: begin
        if (r0_req || r1_req) begin
          take     = 1'b1;
          state_nx = ACCESS;
          // on contention the requester not served last time wins
          if (r0_req && r1_req) gnt_sel = ~last_grant;
          else                  gnt_sel = r1_req;
        end
      end
      ACCESS:  state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign sel_we    = gnt_sel ? r1_we    : r0_we;
  assign sel_addr  = gnt_sel ? r1_addr  : r0_addr;
  assign sel_wdata = gnt_sel ? r1_wdata : r0_wdata;

  // mem_address/mem_data_in double as the latched command registers; the
  // strobes are only high during ACCESS, so their held value is harmless.
  always_ff @(posedge Clock or negedge clear_n) begin
    if (!clear_n) begin
      last_grant  <= 1'b1;
      cur_id      <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      r0_ack      <= 1'b0;
      r1_ack      <= 1'b0;
      r0_rdata    <= '0;
      r1_rdata    <= '0;
      busy        <= 1'b0;
    end else begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      r0_ack    <= 1'b0;
      r1_ack    <= 1'b0;
      busy      <= take || (state == ACCESS);
      if (take) begin
        last_grant  <= gnt_sel;
        cur_id      <= gnt_sel;
        mem_write   <= sel_we;
        mem_read    <= ~sel_we;
        mem_address <= sel_addr;
        mem_data_in <= sel_wdata;
      end
      if (state == ACCESS) begin
        if (cur_id) r1_ack <= 1'b1;
        else        r0_ack <= 1'b1;
        if (mem_read) begin
          if (cur_id) r1_rdata <= mem_data_out;
          else        r0_rdata <= mem_data_out;
        end
      end
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  always_ff @(posedge Clock or negedge clear_n) begin
    if (!clear_n) begin
      r0_grant_cnt <= '0;
      r1_grant_cnt <= '0;
    end else if (take) begin
      if (!gnt_sel && (r0_grant_cnt != {CNT_WIDTH{1'b1}}))
        r0_grant_cnt <= r0_grant_cnt + 1'b1;
      if (gnt_sel && (r1_grant_cnt != {CNT_WIDTH{1'b1}}))
        r1_grant_cnt <= r1_grant_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 9;

  logic          Clock = 1'b0;
  logic          clear_n;
  logic          r0_req, r0_we, r1_req, r1_we;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;
  logic          r0_ack, r1_ack;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic          mem_read, mem_write, busy;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in, mem_data_out;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [15:0]   r0_grant_cnt, r1_grant_cnt;
`endif

  always #5 Clock = ~Clock;

  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .Clock(Clock), .clear_n(clear_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .busy(busy)
`ifdef MEM_ARB_PERF_CNT_EN
    , .r0_grant_cnt(r0_grant_cnt), .r1_grant_cnt(r1_grant_cnt)
`endif
  );

`ifdef MEM_ARB_PERF_CNT_EN
  // narrow-counter instance used only to observe saturation
  logic          sat_req;
  logic          s_r0_ack, s_r1_ack, s_read, s_write, s_busy;
  logic [DW-1:0] s_r0_rdata, s_r1_rdata, s_data_in;
  logic [AW-1:0] s_address;
  logic [1:0]    s_r0_cnt, s_r1_cnt;
  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .CNT_WIDTH(2)) u_sat (
    .Clock(Clock), .clear_n(clear_n),
    .r0_req(sat_req), .r0_we(1'b0), .r0_addr('0), .r0_wdata('0),
    .r0_ack(s_r0_ack), .r0_rdata(s_r0_rdata),
    .r1_req(1'b0), .r1_we(1'b0), .r1_addr('0), .r1_wdata('0),
    .r1_ack(s_r1_ack), .r1_rdata(s_r1_rdata),
    .mem_read(s_read), .mem_write(s_write), .mem_address(s_address),
    .mem_data_in(s_data_in), .mem_data_out('0), .busy(s_busy),
    .r0_grant_cnt(s_r0_cnt), .r1_grant_cnt(s_r1_cnt)
  );
`endif

  // RAM environment: combinational read, write on the falling edge
  logic [DW-1:0] ram [0:(1<<AW)-1];
  assign mem_data_out = ram[mem_address];
  always @(negedge Clock) if (mem_write) ram[mem_address] = mem_data_in;

  // reference model and scoreboard
  typedef struct {
    bit            we;
    logic [DW-1:0] data;
  } exp_t;

  logic [DW-1:0] model_mem [0:(1<<AW)-1];
  exp_t          q0[$], q1[$];
  exp_t          mon_e;
  logic [DW-1:0] hold0, hold1;
  bit            prev_ack0, prev_ack1;
  int            ack_log[$];
  int            ack_cyc0, ack_cyc1;
  int            cyc = 0;
  int            wr_cycles = 0;
  int            checks = 0;
  int            errors = 0;

  always @(posedge Clock) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: pops expectations on each ack and tracks the held rdata
  always @(negedge Clock) begin
    if (!clear_n) begin
      hold0 = '0; hold1 = '0;
      prev_ack0 = 1'b0; prev_ack1 = 1'b0;
    end else begin
      chk("mem_rw_excl", {63'd0, mem_read & mem_write}, 64'd0);
      if (mem_write) wr_cycles++;
      if (r0_ack) begin
        chk("r0_ack_pulse", {63'd0, prev_ack0}, 64'd0);
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL r0_unexpected_ack: got ack expected none");
        end else begin
          mon_e = q0.pop_front();
          if (!mon_e.we) hold0 = mon_e.data;
        end
        ack_log.push_back(0);
        ack_cyc0 = cyc;
      end
      if (r1_ack) begin
        chk("r1_ack_pulse", {63'd0, prev_ack1}, 64'd0);
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL r1_unexpected_ack: got ack expected none");
        end else begin
          mon_e = q1.pop_front();
          if (!mon_e.we) hold1 = mon_e.data;
        end
        ack_log.push_back(1);
        ack_cyc1 = cyc;
      end
      chk("r0_rdata", {32'd0, r0_rdata}, {32'd0, hold0});
      chk("r1_rdata", {32'd0, r1_rdata}, {32'd0, hold1});
      prev_ack0 = r0_ack;
      prev_ack1 = r1_ack;
    end
  end

  // Called at #1 after a rising edge; returns with the same alignment.
  task automatic do_txn(input int id, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, output int lat);
    exp_t e;
    bit   got;
    e.we   = we;
    e.data = we ? '0 : model_mem[addr];
    if (we) model_mem[addr] = wdata;
    if (id == 0) begin
      q0.push_back(e);
      r0_we = we; r0_addr = addr; r0_wdata = wdata; r0_req = 1'b1;
    end else begin
      q1.push_back(e);
      r1_we = we; r1_addr = addr; r1_wdata = wdata; r1_req = 1'b1;
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge Clock); #1;
      lat++;
      got = (id == 0) ? r0_ack : r1_ack;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL ack_timeout r%0d: got no ack expected ack within 40 cycles", id);
    end
    @(posedge Clock); #1;
    if (id == 0) r0_req = 1'b0;
    else         r1_req = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge Clock); #1;
    clear_n = 1'b0;
    r0_req = 1'b0; r1_req = 1'b0;
    q0.delete(); q1.delete(); ack_log.delete();
    #2;
    chk("rst_ctrl", {59'd0, r0_ack, r1_ack, mem_read, mem_write, busy}, 64'd0);
    chk("rst_mem_addr", {55'd0, mem_address}, 64'd0);
    chk("rst_mem_din", {32'd0, mem_data_in}, 64'd0);
    chk("rst_rdata", {r0_rdata, r1_rdata}, 64'd0);
`ifdef MEM_ARB_PERF_CNT_EN
    chk("rst_cnt", {32'd0, r0_grant_cnt, r1_grant_cnt}, 64'd0);
`endif
    @(posedge Clock); #1;
    clear_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  int            lat, lat0, lat1, w0;
  logic [DW-1:0] v;

  initial begin
    clear_n = 1'b0;
    r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
    r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
`ifdef MEM_ARB_PERF_CNT_EN
    sat_req = 1'b0;
`endif
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = '0;
      model_mem[i] = '0;
    end
    apply_reset();

    // simultaneous requests after reset: r0 first, r1 three cycles later
    fork
      do_txn(0, 1'b1, 9'd10,  $urandom, lat0);
      do_txn(1, 1'b1, 9'd300, $urandom, lat1);
    join
    chk("t2_r0_latency", lat0, 2);
    chk("t2_order_len", ack_log.size(), 2);
    if (ack_log.size() == 2) chk("t2_first_r0", ack_log[0], 0);
    chk("t2_ack_spacing", ack_cyc1 - ack_cyc0, 3);

    // continuous requests from both: strict alternation starting with r0
    apply_reset();
    fork
      begin
        int l;
        do_txn(0, 1'b1, 9'd20, $urandom, l);
        do_txn(0, 1'b0, 9'd20, '0, l);
      end
      begin
        int l;
        do_txn(1, 1'b0, 9'd300, '0, l);
        do_txn(1, 1'b1, 9'd301, $urandom, l);
      end
    join
    chk("t3_count", ack_log.size(), 4);
    for (int i = 0; i < 4 && i < ack_log.size(); i++)
      chk("t3_grant_order", ack_log[i], i % 2);
`ifdef MEM_ARB_PERF_CNT_EN
    chk("t6_r0_cnt", r0_grant_cnt, 2);
    chk("t6_r1_cnt", r1_grant_cnt, 2);
`endif

    // write then read back, with latency and write-strobe width
    w0 = wr_cycles;
    do_txn(0, 1'b1, 9'd5, 32'hDEADBEEF, lat);
    chk("t1_wr_latency", lat, 2);
    chk("t1_wr_strobe_cycles", wr_cycles - w0, 1);
    do_txn(0, 1'b0, 9'd5, '0, lat);
    chk("t1_rd_latency", lat, 2);
    chk("t1_rdata", r0_rdata, 32'hDEADBEEF);

    // top address on r1; r0's read data must not move
    do_txn(1, 1'b1, 9'd511, 32'h0000_1234, lat);
    do_txn(1, 1'b0, 9'd511, '0, lat);
    chk("t4_r1_rdata", r1_rdata, 32'h0000_1234);
    chk("t4_r0_unchanged", r0_rdata, 32'hDEADBEEF);

    // reset in the middle of a write ACCESS
    r0_we = 1'b1; r0_addr = 9'd40; r0_wdata = 32'hCAFE_F00D; r0_req = 1'b1;
    @(posedge Clock); #1;
    chk("t5_in_access_wr", mem_write, 1);
    clear_n = 1'b0;
    #1;
    chk("t5_wr_dropped", mem_write, 0);
    chk("t5_no_ack", r0_ack, 0);
    chk("t5_not_busy", busy, 0);
    r0_req = 1'b0;
    @(posedge Clock); #1;
    chk("t5_no_ack_later", r0_ack, 0);
    clear_n = 1'b1;
    v = $urandom;
    do_txn(0, 1'b1, 9'd40, v, lat);
    chk("t5_retry_latency", lat, 2);
    do_txn(0, 1'b0, 9'd40, '0, lat);
    chk("t5_retry_rdata", r0_rdata, v);

    // randomized concurrent traffic; each requester owns half the RAM
    fork
      for (int i = 0; i < 40; i++) begin
        int l;
        do_txn(0, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 255)), $urandom, l);
        repeat ($urandom_range(0, 3)) begin @(posedge Clock); #1; end
      end
      for (int j = 0; j < 40; j++) begin
        int l;
        do_txn(1, 1'($urandom_range(0, 1)), 9'($urandom_range(256, 511)), $urandom, l);
        repeat ($urandom_range(0, 3)) begin @(posedge Clock); #1; end
      end
    join
    repeat (3) begin @(posedge Clock); #1; end
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);

`ifdef MEM_ARB_PERF_CNT_EN
    apply_reset();
    sat_req = 1'b1;
    repeat (20) begin @(posedge Clock); #1; end
    sat_req = 1'b0;
    repeat (3) begin @(posedge Clock); #1; end
    chk("t6_sat_r0", s_r0_cnt, 3);
    chk("t6_sat_r1", s_r1_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
